fft_bitrev_reorder: RTL and testbench
=====================================

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter MAX_NUM_OF_SIGNALS, default 8, meaning FFT frame length N; power of two, 4..1024.
REQ-002 SHALL have parameter SIZE_OF_SIGNAL, default 50, meaning signed sample width W.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port s_data_i, input, W, signed FFT output sample in bit-reversed order.
REQ-006 SHALL have port s_valid_i, input, 1, input sample valid.
REQ-007 SHALL have port s_last_i, input, 1, marks the final sample of an input frame.
REQ-008 SHALL have port s_ready_o, output, 1, block can accept an input sample.
REQ-009 SHALL have port m_data_o, output, W, signed sample in natural order.
REQ-010 SHALL have port m_valid_o, output, 1, output sample valid.
REQ-011 SHALL have port m_last_o, output, 1, marks output sample index N-1.
REQ-012 SHALL have port m_ready_i, input, 1, downstream accepts the output sample.
REQ-013 SHALL have port frame_err_o, output, 1, sticky flag for an s_last_i position mismatch.

Function
REQ-014 SHALL hold two banks (A, B) of N x W storage operated ping-pong, with one write-bank pointer, one read-bank pointer and one full flag per bank.
REQ-015 SHALL accept an input beat when s_valid_i && s_ready_o, with s_ready_o = !full[wr_sel].
REQ-016 SHALL write each accepted beat to address bitrev(wr_cnt) of bank wr_sel, where bitrev reverses the log2(N) bits of wr_cnt, then increment wr_cnt.
REQ-017 SHALL, on the beat accepted with wr_cnt == N-1, set full[wr_sel], toggle wr_sel and wrap wr_cnt to 0.
REQ-018 SHALL set frame_err_o (sticky until reset) when an accepted beat has s_last_i != (wr_cnt == N-1); the frame boundary is still decided by wr_cnt alone.
REQ-019 SHALL drive m_valid_o = full[rd_sel], m_data_o = bank[rd_sel][rd_cnt] and m_last_o = m_valid_o && (rd_cnt == N-1); all three are decoded from registers.
REQ-020 SHALL, on m_valid_o && m_ready_i, increment rd_cnt; at rd_cnt == N-1 it SHALL clear full[rd_sel], toggle rd_sel and wrap rd_cnt to 0.
REQ-021 SHALL hold m_data_o, m_last_o and m_valid_o stable while m_valid_o && !m_ready_i.
REQ-022 SHALL assert m_valid_o in the cycle after the frame's last input beat is accepted (1-cycle latency, frame to first output).
REQ-023 SHALL sustain one beat per cycle in and one per cycle out when m_ready_i is held high.
REQ-024 SHALL, when both banks are full, deassert s_ready_o until the read side releases a bank.
REQ-025 SHALL allow s_ready_o to rise in the cycle after the last read of a bank.
REQ-026 SHALL apply both updates when a bank is completed by the write side and the other bank is released by the read side in the same cycle.
REQ-027 SHALL pass samples bit-exact, with no arithmetic or width change.

Reset
REQ-028 SHALL, while rst_i is low, asynchronously clear wr_cnt, rd_cnt, wr_sel, rd_sel, both full flags and frame_err_o.
REQ-029 SHALL therefore drive, in reset, m_valid_o=0, m_last_o=0 and s_ready_o=1.
REQ-030 SHALL NOT reset bank storage; m_data_o is don't-care while m_valid_o=0.
REQ-031 SHALL, when reset is asserted mid-frame, discard the partial frame and any buffered frames.

Structure
REQ-032 SHALL take MAX_NUM_OF_SIGNALS, SIZE_OF_SIGNAL, LOG2_N and a bitrev function from shared package fft_pkg.
REQ-033 SHALL instantiate storage as sub-module fft_reorder_bank (1 write port, 1 asynchronous read port, N x W), used twice.

Verification
REQ-034 Single frame: N=8, inputs 100,104,102,106,101,105,103,107 (s_last on the 8th), m_ready=1 -> outputs 100..107 in order, first output one cycle after the 8th input, m_last on 107.
REQ-035 Back-to-back: 4 consecutive frames, s_valid and m_ready held high -> s_ready never drops; 32 outputs all in natural order.
REQ-036 Backpressure: m_ready=0 and 3 frames offered -> s_ready falls after the 16th beat; then m_ready=1 -> s_ready rises after the 8th output; no data lost.
REQ-037 Framing error: s_last asserted on the 5th beat -> frame_err_o=1 and stays high; the frame still completes after the 8th beat.
REQ-038 Reset mid-frame: 3 beats accepted, then rst_i low for 2 cycles -> m_valid=0, s_ready=1, frame_err_o=0; the next full frame reorders correctly.
REQ-039 Stall stability: m_ready toggled randomly -> m_data_o/m_last_o unchanged while stalled; output sequence matches the golden natural order.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT bit-reversal reorder buffer.
// Holds the default frame length / sample width, the log2 of the frame
// length, the bank-select enumeration and a generic bit-reverse helper.
package fft_pkg;

  localparam int unsigned MAX_NUM_OF_SIGNALS = 8;
  localparam int unsigned SIZE_OF_SIGNAL     = 50;
  localparam int unsigned LOG2_N             = $clog2(MAX_NUM_OF_SIGNALS);

  // Widest index supported (N up to 1024).
  localparam int unsigned MAX_LOG2 = 10;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_sel_e;

  // Reverse the low 'bits' bits of v; bits above 'bits' come back as zero.
  function automatic logic [MAX_LOG2-1:0] bitrev(input logic [MAX_LOG2-1:0] v,
                                                 input int unsigned         bits);
    logic [MAX_LOG2-1:0] r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < MAX_LOG2; i++) begin
      if (i < bits) begin
        j = bits - 1 - i;
        r[j[3:0]] = v[i[3:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N x W sample bank: single synchronous write port, single
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module fft_reorder_bank #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 50,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders FFT output frames from bit-reversed to natural order using two
// ping-pong banks. The write side scatters each incoming beat to
// bitrev(wr_cnt); the read side streams the completed bank linearly.
// Ports:
//   clk_i       - clock
//   rst_i       - asynchronous active-low reset
//   s_data_i    - input sample (bit-reversed order)
//   s_valid_i   - input valid
//   s_last_i    - input last beat of frame marker
//   s_ready_o   - block can accept an input beat
//   m_data_o    - output sample (natural order)
//   m_valid_o   - output valid
//   m_last_o    - output is sample N-1 of the frame
//   m_ready_i   - downstream accepts output
//   frame_err_o - sticky: s_last_i disagreed with the beat position
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned MAX_NUM_OF_SIGNALS = fft_pkg::MAX_NUM_OF_SIGNALS,
  parameter int unsigned SIZE_OF_SIGNAL     = fft_pkg::SIZE_OF_SIGNAL
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SIZE_OF_SIGNAL-1:0] s_data_i,
  input  logic                      s_valid_i,
  input  logic                      s_last_i,
  output logic                      s_ready_o,
  output logic [SIZE_OF_SIGNAL-1:0] m_data_o,
  output logic                      m_valid_o,
  output logic                      m_last_o,
  input  logic                      m_ready_i,
  output logic                      frame_err_o
);

  localparam int unsigned   AW       = $clog2(MAX_NUM_OF_SIGNALS);
  localparam logic [AW-1:0] LAST_IDX = AW'(MAX_NUM_OF_SIGNALS - 1);

  bank_sel_e                 wr_sel, rd_sel;
  logic [AW-1:0]             wr_cnt, rd_cnt, waddr;
  logic [1:0]                full;
  logic [SIZE_OF_SIGNAL-1:0] rdata_a, rdata_b;
  logic                      wr_full, rd_full;
  logic                      s_fire, m_fire, wr_wrap, rd_wrap;
  logic                      we_a, we_b;

  always_comb begin
    wr_full   = full[wr_sel == BANK_B];
    rd_full   = full[rd_sel == BANK_B];
    s_ready_o = !wr_full;
    s_fire    = s_valid_i && !wr_full;
    wr_wrap   = s_fire && (wr_cnt == LAST_IDX);
    m_valid_o = rd_full;
    m_last_o  = rd_full && (rd_cnt == LAST_IDX);
    m_fire    = rd_full && m_ready_i;
    rd_wrap   = m_fire && (rd_cnt == LAST_IDX);
    m_data_o  = (rd_sel == BANK_A) ? rdata_a : rdata_b;
    waddr     = AW'(bitrev(MAX_LOG2'(wr_cnt), AW));
    we_a      = s_fire && (wr_sel == BANK_A);
    we_b      = s_fire && (wr_sel == BANK_B);
  end

  // A write completion and a read release can land in the same cycle; they
  // always target different banks (one is empty, the other full), so both
  // full-flag updates are applied independently.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wr_sel      <= BANK_A;
      rd_sel      <= BANK_A;
      full        <= '0;
      frame_err_o <= 1'b0;
    end else begin
      if (s_fire) begin
        wr_cnt <= wr_wrap ? '0 : wr_cnt + 1'b1;
        if (s_last_i != (wr_cnt == LAST_IDX)) frame_err_o <= 1'b1;
      end
      if (wr_wrap) begin
        full[wr_sel == BANK_B] <= 1'b1;
        wr_sel <= (wr_sel == BANK_A) ? BANK_B : BANK_A;
      end
      if (m_fire) rd_cnt <= rd_wrap ? '0 : rd_cnt + 1'b1;
      if (rd_wrap) begin
        full[rd_sel == BANK_B] <= 1'b0;
        rd_sel <= (rd_sel == BANK_A) ? BANK_B : BANK_A;
      end
    end
  end

  fft_reorder_bank #(
    .DEPTH (MAX_NUM_OF_SIGNALS),
    .WIDTH (SIZE_OF_SIGNAL),
    .AW    (AW)
  ) u_bank_a (
    .clk   (clk_i),
    .we    (we_a),
    .waddr (waddr),
    .wdata (s_data_i),
    .raddr (rd_cnt),
    .rdata (rdata_a)
  );

  fft_reorder_bank #(
    .DEPTH (MAX_NUM_OF_SIGNALS),
    .WIDTH (SIZE_OF_SIGNAL),
    .AW    (AW)
  ) u_bank_b (
    .clk   (clk_i),
    .we    (we_b),
    .waddr (waddr),
    .wdata (s_data_i),
    .raddr (rd_cnt),
    .rdata (rdata_b)
  );

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: N=8, W=50. A frame-level reference model
// tracks buffered frames, the natural-order output stream and the sticky
// framing flag; every cycle the DUT outputs are compared against it.
module tb_fft_bitrev_reorder;

  localparam int N = 8;
  localparam int W = 50;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] s_data_i;
  logic         s_valid_i;
  logic         s_last_i;
  logic         s_ready_o;
  logic [W-1:0] m_data_o;
  logic         m_valid_o;
  logic         m_last_o;
  logic         m_ready_i;
  logic         frame_err_o;

  fft_bitrev_reorder #(
    .MAX_NUM_OF_SIGNALS (N),
    .SIZE_OF_SIGNAL     (W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_last_o    (m_last_o),
    .m_ready_i   (m_ready_i),
    .frame_err_o (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] in_data_q[$];
  logic         in_last_q[$];
  logic [W-1:0] exp_q[$];
  int           frames_full;
  int           wr_pos;
  int           rd_pos;
  logic         err_model;
  logic         stall_prev;
  logic [W-1:0] prev_data;
  logic         prev_last;
  int           mready_mode;   // 0 low, 1 high, 2 random
  logic         gap_en;
  int           ready_drops;
  int           outs_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 3; b++) r = r * 2 + ((k / (1 << b)) % 2);
    return r;
  endfunction

  // Queue a frame given in natural order; optionally put s_last on a wrong beat.
  task automatic add_frame(input logic [W-1:0] x [N], input int last_beat);
    for (int k = 0; k < N; k++) begin
      in_data_q.push_back(x[brev(k)]);
      in_last_q.push_back(k == last_beat);
    end
    for (int k = 0; k < N; k++) exp_q.push_back(x[k]);
  endtask

  task automatic add_random_frame();
    logic [W-1:0] x [N];
    for (int k = 0; k < N; k++) x[k] = W'({$urandom(), $urandom()});
    add_frame(x, N - 1);
  endtask

  task automatic drive_inputs();
    if (in_data_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      s_valid_i = 1'b1;
      s_data_i  = in_data_q[0];
      s_last_i  = in_last_q[0];
    end else begin
      s_valid_i = 1'b0;
      s_data_i  = W'({$urandom(), $urandom()});
      s_last_i  = 1'($urandom_range(0, 1));
    end
    case (mready_mode)
      0:       m_ready_i = 1'b0;
      1:       m_ready_i = 1'b1;
      default: m_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Check outputs at negedge against the model, then advance the model with
  // the handshakes that the coming rising edge will perform.
  task automatic step();
    logic exp_ready, exp_valid;
    @(negedge clk_i);
    exp_ready = (frames_full < 2);
    exp_valid = (frames_full > 0);
    chk("s_ready", s_ready_o, exp_ready);
    chk("m_valid", m_valid_o, exp_valid);
    chk("m_last", m_last_o, exp_valid && (rd_pos == N - 1));
    chk("frame_err", frame_err_o, err_model);
    if (!s_ready_o) ready_drops++;
    if (stall_prev) begin
      chk("stall_data", m_data_o, prev_data);
      chk("stall_last", m_last_o, prev_last);
    end
    if (exp_valid && exp_q.size() > 0) chk("m_data", m_data_o, exp_q[0]);
    if (exp_valid && m_ready_i) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      outs_seen++;
      rd_pos++;
      if (rd_pos == N) begin
        rd_pos = 0;
        frames_full--;
      end
    end
    if (s_valid_i && exp_ready) begin
      if (s_last_i != (wr_pos == N - 1)) err_model = 1'b1;
      void'(in_data_q.pop_front());
      void'(in_last_q.pop_front());
      wr_pos++;
      if (wr_pos == N) begin
        wr_pos = 0;
        frames_full++;
      end
    end
    stall_prev = exp_valid && !m_ready_i;
    prev_data  = m_data_o;
    prev_last  = m_last_o;
    @(posedge clk_i);
    #1;
    drive_inputs();
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 400;
    while ((exp_q.size() > 0 || in_data_q.size() > 0) && budget > 0) begin
      step();
      budget--;
    end
    chk(tag, exp_q.size() + in_data_q.size(), 0);
  endtask

  task automatic do_reset(input int cycles);
    rst_i     = 1'b0;
    s_valid_i = 1'b0;
    in_data_q.delete();
    in_last_q.delete();
    exp_q.delete();
    frames_full = 0;
    wr_pos      = 0;
    rd_pos      = 0;
    err_model   = 1'b0;
    stall_prev  = 1'b0;
    repeat (cycles) begin
      @(negedge clk_i);
      chk("rst_m_valid", m_valid_o, 1'b0);
      chk("rst_m_last", m_last_o, 1'b0);
      chk("rst_s_ready", s_ready_o, 1'b1);
      chk("rst_frame_err", frame_err_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    drive_inputs();
  endtask

  initial begin
    logic [W-1:0] f [N];
    rst_i       = 1'b1;
    s_valid_i   = 1'b0;
    s_data_i    = '0;
    s_last_i    = 1'b0;
    m_ready_i   = 1'b0;
    mready_mode = 1;
    gap_en      = 1'b0;
    #2;
    do_reset(2);

    // Single directed frame: natural 100..107 fed in bit-reversed order.
    for (int k = 0; k < N; k++) f[k] = W'(100 + k);
    add_frame(f, N - 1);
    drive_inputs();
    repeat (N) step();
    chk("latency_valid", m_valid_o, 1'b1);
    chk("first_out", m_data_o, W'(100));
    drain("single_drain");

    // Back-to-back frames at full rate.
    ready_drops = 0;
    for (int i = 0; i < 4; i++) add_random_frame();
    drive_inputs();
    drain("b2b_drain");
    chk("b2b_no_ready_drop", ready_drops, 0);

    // Backpressure: 3 frames offered with m_ready low.
    mready_mode = 0;
    for (int i = 0; i < 3; i++) add_random_frame();
    drive_inputs();
    repeat (24) step();
    chk("bp_ready_low", s_ready_o, 1'b0);
    chk("bp_pending", in_data_q.size(), N);
    mready_mode = 1;
    outs_seen   = 0;
    drive_inputs();
    while (outs_seen < N) step();
    chk("bp_ready_rise", s_ready_o, 1'b1);
    drain("bp_drain");

    // Framing error: s_last on the 5th beat.
    for (int k = 0; k < N; k++) f[k] = W'({$urandom(), $urandom()});
    add_frame(f, 4);
    drive_inputs();
    drain("ferr_drain");
    repeat (3) step();
    chk("ferr_sticky", frame_err_o, 1'b1);

    // Reset mid-frame after 3 accepted beats.
    add_random_frame();
    drive_inputs();
    repeat (3) step();
    do_reset(2);
    add_random_frame();
    drive_inputs();
    drain("post_reset_drain");

    // Random stalls and input gaps.
    mready_mode = 2;
    gap_en      = 1'b1;
    for (int i = 0; i < 5; i++) add_random_frame();
    drive_inputs();
    drain("random_drain");
    mready_mode = 1;
    drive_inputs();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
